// File: rtl/adder_tree_pkg.sv
// adder_tree_pkg: width and pipelining helpers shared by the adder tree levels and top
package adder_tree_pkg;

    function automatic int stage_width(input int idata_width, input int stage);
        return idata_width + stage;
    endfunction

    function automatic bit stage_registered(input int stage, input int pipe_every);
        return pipe_every != 0 && stage % pipe_every == 0;
    endfunction

    function automatic int num_reg_stages(input int stages_num, input int pipe_every);
        return pipe_every == 0 ? 0 : stages_num / pipe_every;
    endfunction

endpackage

// File: rtl/adder_tree_level.sv
// adder_tree_level: one tree level, pairwise add with one growth bit and valid/last sideband
module adder_tree_level #(
    parameter int LANES = 2,
    parameter int IW = 4,
    parameter bit SIGNED = 0,
    parameter bit REGISTERED = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic [LANES-1:0][IW-1:0]      din,
    input  logic                          vin,
    input  logic                          lin,
    output logic [LANES/2-1:0][IW:0]      dout,
    output logic                          vout,
    output logic                          lout
);
    logic [LANES/2-1:0][IW:0] sum;

    always_comb
        for (int k = 0; k < LANES / 2; k++)
            sum[k] = {SIGNED & din[2*k][IW-1], din[2*k]} + {SIGNED & din[2*k+1][IW-1], din[2*k+1]};

    if (REGISTERED) begin : r
        always_ff @(posedge clk)
            if (rst) begin
                dout <= '0;
                vout <= 1'b0;
                lout <= 1'b0;
            end else if (en) begin
                dout <= sum;
                vout <= vin;
                lout <= lin;
            end
    end else begin : c
        logic unused_ok;
        assign unused_ok = ^{clk, rst, en};
        assign dout = sum;
        assign vout = vin;
        assign lout = lin;
    end

endmodule

// File: rtl/adder_tree_stream.sv
// adder_tree_stream: pipelined lane adder tree with packet accumulation and valid/ready handshake
module adder_tree_stream
    import adder_tree_pkg::*;
#(
    parameter int INPUTS_NUM = 125,
    parameter int IDATA_WIDTH = 16,
    parameter int SIGNED = 0,
    parameter int PIPE_EVERY = 1,
    parameter int ACC_WIDTH = 8,
    parameter int STAGES_NUM = $clog2(INPUTS_NUM),
    parameter int ODATA_WIDTH = IDATA_WIDTH + STAGES_NUM + ACC_WIDTH
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [INPUTS_NUM-1:0][IDATA_WIDTH-1:0] idata,
    input  logic                                   ivalid,
    input  logic                                   ilast,
    output logic                                   iready,
    output logic [ODATA_WIDTH-1:0]                 odata,
    output logic                                   ovalid,
    input  logic                                   oready,
    output logic                                   ooverflow
);
    localparam int N2 = 1 << STAGES_NUM;
    localparam int SW = stage_width(IDATA_WIDTH, STAGES_NUM);
    localparam int OW = ODATA_WIDTH;

    logic en;
    assign en = ~ovalid | oready;
    assign iready = en;

    for (genvar s = 0; s <= STAGES_NUM; s++) begin : g
        logic [(N2>>s)-1:0][stage_width(IDATA_WIDTH, s)-1:0] d;
        logic v, l;
        if (s == 0) begin : b
            // pad to a power of two with zero lanes
            for (genvar k = 0; k < N2; k++) begin : p
                if (k < INPUTS_NUM) begin : u
                    assign d[k] = idata[k];
                end else begin : z
                    assign d[k] = '0;
                end
            end
            assign v = ivalid;
            assign l = ilast;
        end else begin : b
            adder_tree_level #(
                .LANES(N2 >> (s - 1)),
                .IW(stage_width(IDATA_WIDTH, s - 1)),
                .SIGNED(SIGNED != 0),
                .REGISTERED(stage_registered(s, PIPE_EVERY))
            ) u (
                .clk(clk),
                .rst(rst),
                .en(en),
                .din(g[s-1].d),
                .vin(g[s-1].v),
                .lin(g[s-1].l),
                .dout(d),
                .vout(v),
                .lout(l)
            );
        end
    end

    logic [SW-1:0] tsum;
    logic          tv, tl;
    assign tsum = g[STAGES_NUM].d[0];
    assign tv = g[STAGES_NUM].v;
    assign tl = g[STAGES_NUM].l;

    logic [OW-1:0] sum_ext, acc, acc_next;
    logic          carry, wrap, ovf_acc, ovf_now;

    always_comb begin
        sum_ext = OW'(tsum);
        if (SIGNED != 0) sum_ext = OW'($signed(tsum));
        {carry, acc_next} = {1'b0, acc} + {1'b0, sum_ext};
        wrap = SIGNED != 0 ? (acc[OW-1] == sum_ext[OW-1]) && (acc_next[OW-1] != acc[OW-1]) : carry;
        ovf_now = ovf_acc | wrap;
    end

    always_ff @(posedge clk)
        if (rst) begin
            acc <= '0;
            ovf_acc <= 1'b0;
            odata <= '0;
            ovalid <= 1'b0;
            ooverflow <= 1'b0;
        end else if (en) begin
            ovalid <= tv & tl;
            if (tv & tl) begin
                odata <= acc_next;
                ooverflow <= ovf_now;
            end
            acc <= tv ? (tl ? '0 : acc_next) : acc;
            ovf_acc <= tv ? ovf_now & ~tl : ovf_acc;
        end

endmodule

// File: tb/tb_adder_tree_stream.sv
// tb_adder_tree_stream: directed checks on four configurations sharing one stimulus stream
module tb_adder_tree_stream;
    logic clk = 0, rst = 1, ivalid = 0, ilast = 0, oready = 1;
    logic [4:0][3:0] idata = '0;
    logic [8:0] od [4];
    logic ov [4], oo [4], ir [4];
    int pass = 0, total = 0;

    always #5 clk = ~clk;

    // u0 unsigned PE=1, u1 signed PE=1, u2 unsigned PE=0, u3 unsigned PE=2
    adder_tree_stream #(.INPUTS_NUM(5), .IDATA_WIDTH(4), .SIGNED(0), .PIPE_EVERY(1), .ACC_WIDTH(2)) u0 (
        .clk(clk), .rst(rst), .idata(idata), .ivalid(ivalid), .ilast(ilast), .iready(ir[0]),
        .odata(od[0]), .ovalid(ov[0]), .oready(oready), .ooverflow(oo[0]));
    adder_tree_stream #(.INPUTS_NUM(5), .IDATA_WIDTH(4), .SIGNED(1), .PIPE_EVERY(1), .ACC_WIDTH(2)) u1 (
        .clk(clk), .rst(rst), .idata(idata), .ivalid(ivalid), .ilast(ilast), .iready(ir[1]),
        .odata(od[1]), .ovalid(ov[1]), .oready(oready), .ooverflow(oo[1]));
    adder_tree_stream #(.INPUTS_NUM(5), .IDATA_WIDTH(4), .SIGNED(0), .PIPE_EVERY(0), .ACC_WIDTH(2)) u2 (
        .clk(clk), .rst(rst), .idata(idata), .ivalid(ivalid), .ilast(ilast), .iready(ir[2]),
        .odata(od[2]), .ovalid(ov[2]), .oready(oready), .ooverflow(oo[2]));
    adder_tree_stream #(.INPUTS_NUM(5), .IDATA_WIDTH(4), .SIGNED(0), .PIPE_EVERY(2), .ACC_WIDTH(2)) u3 (
        .clk(clk), .rst(rst), .idata(idata), .ivalid(ivalid), .ilast(ilast), .iready(ir[3]),
        .odata(od[3]), .ovalid(ov[3]), .oready(oready), .ooverflow(oo[3]));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [19:0] d, input logic last);
        int n = 0;
        idata = d;
        ivalid = 1;
        ilast = last;
        while (!ir[0] && n < 50) begin
            tick();
            n++;
        end
        if (n == 50) begin
            $display("FAIL beat_accept iready stuck low for %0d cycles, want 1", n);
            $fatal(1);
        end
        tick();
        ivalid = 0;
        ilast = 0;
    endtask

    // lat counts edges starting with the accepting edge
    task automatic wait_out(input int i, output int lat, output logic [8:0] d, output logic o);
        lat = 1;
        while (!ov[i] && lat < 20) begin
            tick();
            lat++;
        end
        d = od[i];
        o = oo[i];
    endtask

    task automatic test_reset();
        rst = 1;
        repeat (3) tick();
        rst = 0;
        for (int i = 0; i < 4; i++) begin
            total++; if (ov[i] !== 1'b0) $display("FAIL reset_ovalid[%0d] got %b want 0", i, ov[i]); else pass++;
            total++; if (od[i] !== 9'd0) $display("FAIL reset_odata[%0d] got %0d want 0", i, od[i]); else pass++;
            total++; if (oo[i] !== 1'b0) $display("FAIL reset_ooverflow[%0d] got %b want 0", i, oo[i]); else pass++;
            total++; if (ir[i] !== 1'b1) $display("FAIL reset_iready[%0d] got %b want 1", i, ir[i]); else pass++;
        end
    endtask

    task automatic test_unsigned();
        int lat; logic [8:0] d; logic o;
        beat(20'hFFFFF, 1);
        wait_out(0, lat, d, o);
        total++; if (lat !== 4) $display("FAIL unsigned_latency got %0d want 4", lat); else pass++;
        total++; if (d !== 9'd75) $display("FAIL unsigned_odata got %0d want 75", d); else pass++;
        total++; if (o !== 1'b0) $display("FAIL unsigned_ooverflow got %b want 0", o); else pass++;
        tick();
        total++; if (ov[0] !== 1'b0) $display("FAIL unsigned_single_pulse got %b want 0", ov[0]); else pass++;
    endtask

    task automatic test_signed();
        int lat; logic [8:0] d; logic o;
        beat(20'h88888, 1);
        wait_out(1, lat, d, o);
        total++; if (lat !== 4) $display("FAIL signed_latency got %0d want 4", lat); else pass++;
        total++; if (d !== 9'h1D8) $display("FAIL signed_odata got %h want 1d8", d); else pass++;
        total++; if (o !== 1'b0) $display("FAIL signed_ooverflow got %b want 0", o); else pass++;
        tick();
    endtask

    task automatic test_multi_beat();
        int lat; logic [8:0] d; logic o;
        beat(20'h54321, 0);
        total++; if (ov[0] !== 1'b0) $display("FAIL multi_beat1_ovalid got %b want 0", ov[0]); else pass++;
        beat(20'h54321, 0);
        total++; if (ov[0] !== 1'b0) $display("FAIL multi_beat2_ovalid got %b want 0", ov[0]); else pass++;
        beat(20'h54321, 1);
        wait_out(0, lat, d, o);
        total++; if (lat !== 4) $display("FAIL multi_latency got %0d want 4", lat); else pass++;
        total++; if (d !== 9'd45) $display("FAIL multi_odata got %0d want 45", d); else pass++;
        tick();
        total++; if (ov[0] !== 1'b0) $display("FAIL multi_single_result got %b want 0", ov[0]); else pass++;
    endtask

    task automatic test_backpressure();
        int lat; logic [8:0] d; logic o;
        beat(20'h54321, 1);
        beat(20'h22222, 1);
        wait_out(0, lat, d, o);
        total++; if (lat !== 3) $display("FAIL bp_first_arrival got %0d want 3", lat); else pass++;
        total++; if (d !== 9'd15) $display("FAIL bp_first_odata got %0d want 15", d); else pass++;
        oready = 0;
        for (int c = 0; c < 5; c++) begin
            tick();
            total++; if (od[0] !== 9'd15) $display("FAIL bp_hold_odata c%0d got %0d want 15", c, od[0]); else pass++;
            total++; if (ov[0] !== 1'b1) $display("FAIL bp_hold_ovalid c%0d got %b want 1", c, ov[0]); else pass++;
            total++; if (ir[0] !== 1'b0) $display("FAIL bp_hold_iready c%0d got %b want 0", c, ir[0]); else pass++;
        end
        oready = 1;
        tick();
        total++; if (ov[0] !== 1'b1) $display("FAIL bp_refill_ovalid got %b want 1", ov[0]); else pass++;
        total++; if (od[0] !== 9'd10) $display("FAIL bp_refill_odata got %0d want 10", od[0]); else pass++;
        tick();
        total++; if (ov[0] !== 1'b0) $display("FAIL bp_no_duplicate got %b want 0", ov[0]); else pass++;
    endtask

    task automatic test_overflow();
        int lat; logic [8:0] d; logic o;
        for (int k = 1; k <= 7; k++) beat(20'hFFFFF, k == 7);
        wait_out(0, lat, d, o);
        total++; if (lat !== 4) $display("FAIL ovf_latency got %0d want 4", lat); else pass++;
        total++; if (d !== 9'd13) $display("FAIL ovf_odata got %0d want 13", d); else pass++;
        total++; if (o !== 1'b1) $display("FAIL ovf_flag got %b want 1", o); else pass++;
        beat(20'h11111, 1);
        wait_out(0, lat, d, o);
        total++; if (d !== 9'd5) $display("FAIL ovf_next_odata got %0d want 5", d); else pass++;
        total++; if (o !== 1'b0) $display("FAIL ovf_next_flag got %b want 0", o); else pass++;
        tick();
    endtask

    task automatic test_reset_sweep();
        int lat [4]; logic [8:0] dd [4];
        int want_lat [4] = '{4, 4, 1, 2};
        beat(20'h22222, 0);
        beat(20'h22222, 0);
        rst = 1;
        tick();
        rst = 0;
        total++; if (ov[0] !== 1'b0) $display("FAIL sweep_rst_ovalid_pe1 got %b want 0", ov[0]); else pass++;
        total++; if (ov[2] !== 1'b0) $display("FAIL sweep_rst_ovalid_pe0 got %b want 0", ov[2]); else pass++;
        total++; if (ov[3] !== 1'b0) $display("FAIL sweep_rst_ovalid_pe2 got %b want 0", ov[3]); else pass++;
        for (int i = 0; i < 4; i++) begin
            lat[i] = 0;
            dd[i] = '0;
        end
        beat(20'h22222, 1);
        for (int c = 1; c <= 8; c++) begin
            for (int i = 0; i < 4; i++)
                if (ov[i] && lat[i] == 0) begin
                    lat[i] = c;
                    dd[i] = od[i];
                end
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            if (i == 1) continue;
            total++; if (lat[i] !== want_lat[i]) $display("FAIL sweep_latency[u%0d] got %0d want %0d", i, lat[i], want_lat[i]); else pass++;
            total++; if (dd[i] !== 9'd10) $display("FAIL sweep_odata[u%0d] got %0d want 10", i, dd[i]); else pass++;
        end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_multi_beat();
        test_backpressure();
        test_overflow();
        test_reset_sweep();
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end

endmodule
